btb_write_ctrl: RTL

Owns the single write port of the 2048x16 branch prediction cache (BTB).
It sequences a full invalidation sweep after reset or on flush request, and buffers execute-stage BTB updates (valid | pc[12:11] | jumppc) in a small coalescing FIFO.
Updates drain whenever the fetch stage is not using the single-ported BTB.
It sits between the execute-stage PC calculation (update source) and the BTB RAM; fetch uses btb_ready to qualify predictions.

---
 rtl/btb_write_ctrl_pkg.sv | 19 +
 rtl/btb_write_ctrl_upd_fifo.sv | 116 +++++++++++
 rtl/btb_write_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/btb_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// btb_write_ctrl_pkg
// Shared definitions for the BTB write controller: default geometry of the
// 2048x16 branch target buffer and the controller state encoding.
// An entry is {valid, pc[12:11], jumppc}. The valid bit is the MSB, so an
// all-zero word is an invalid entry. That is why the sweep writes zeros.
// ---------------------------------------------------------------------------
package btb_write_ctrl_pkg;

  localparam int BTB_ADDR_W = 11;  // index is pc[10:0]
  localparam int BTB_DATA_W = 16;  // entry width, MSB is the valid bit
  localparam int BTB_DEPTH  = 4;   // update FIFO entries

  typedef enum logic {
    ST_SWEEP = 1'b0,  // invalidating every BTB index, BTB not trustworthy
    ST_RUN   = 1'b1   // draining execute-stage updates
  } btb_state_e;

endpackage

// File: rtl/btb_write_ctrl_upd_fifo.sv
// ---------------------------------------------------------------------------
// btb_write_ctrl_upd_fifo
// Circular FIFO of pending BTB updates. Every live entry is compared with the
// incoming address in parallel, so the owner can coalesce a new update into
// an entry that is already queued. When that happens the entry's data is
// overwritten in place.
//
// Ports
//   clk, rst             clock, async active-high reset
//   clear                drop all entries (flush)
//   push                 append in_addr/in_data as a new tail entry
//   pop                  remove the head entry
//   coal                 overwrite the data of the matching entry
//   in_addr, in_data     incoming update
//   match                in_addr hits a live entry; the entry popped this
//                        cycle does not count as a hit
//   head_addr, head_data oldest entry
//   level, full, empty   occupancy
// ---------------------------------------------------------------------------
module btb_write_ctrl_upd_fifo
  import btb_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = BTB_ADDR_W,
  parameter int DATA_W = BTB_DATA_W,
  parameter int DEPTH  = BTB_DEPTH,
  parameter int PW     = $clog2(DEPTH),
  parameter int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              coal,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              match,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [DEPTH-1:0]  match_vec;
  logic [PW-1:0]     match_idx;

  // A slot is live when its distance from the head is less than the
  // occupancy. The head slot is masked out when it leaves this cycle, so an
  // update to the popped address becomes a fresh tail entry. It does not
  // modify data that is already on its way to the BTB.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] offs;
      logic          live;
      logic          leaving;
      assign offs         = PW'(gi) - rd_ptr_reg;
      assign live         = {1'b0, offs} < level_reg;
      assign leaving      = pop && (PW'(gi) == rd_ptr_reg);
      assign match_vec[gi] = live && !leaving && (addr_mem[gi] == in_addr);
    end
  endgenerate

  // Coalescing keeps the queued addresses unique, so at most one bit is set.
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) match_idx = PW'(i);
    end
  end

  assign match     = |match_vec;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign level     = level_reg;
  assign full      = (level_reg == LW'(DEPTH));
  assign empty     = (level_reg == '0);

  // Storage needs no reset because liveness comes from the pointers.
  // When the FIFO is full and pushes and pops in the same cycle, the push
  // lands in the slot being vacated. That is safe because the head is read
  // before the edge.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push) begin
        addr_mem[wr_ptr_reg] <= in_addr;
        data_mem[wr_ptr_reg] <= in_data;
      end
      if (coal) begin
        data_mem[match_idx] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      level_reg <= level_reg + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/btb_write_ctrl.sv
// ---------------------------------------------------------------------------
// btb_write_ctrl
// Owns the single write port of the BTB. After reset or a flush it writes
// zero (invalid) to every index. After that it forwards execute-stage
// updates to the BTB. Updates are issued only in cycles where fetch is not
// reading, and they are buffered in a coalescing FIFO while fetch holds the
// port.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   upd_wen, upd_addr, upd_data      execute-stage update request
//   flush_req                        invalidate the whole BTB (1-cycle pulse)
//   fetch_rd                         fetch owns the BTB port this cycle
//   btb_wen, btb_waddr, btb_wdata    registered BTB write port
//   btb_ready                        BTB contents are valid
//   fifo_level                       queued updates after the edge
//   drop_cnt                         saturating count of overflow drops
// ---------------------------------------------------------------------------
module btb_write_ctrl
  import btb_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = BTB_ADDR_W,
  parameter int DATA_W = BTB_DATA_W,
  parameter int DEPTH  = BTB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_wen,
  input  logic [ADDR_W-1:0]          upd_addr,
  input  logic [DATA_W-1:0]          upd_data,
  input  logic                       flush_req,
  input  logic                       fetch_rd,
  output logic                       btb_wen,
  output logic [ADDR_W-1:0]          btb_waddr,
  output logic [DATA_W-1:0]          btb_wdata,
  output logic                       btb_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  btb_state_e        state_reg, state_next;
  // One extra bit: the MSB is set once the last index has been written.
  logic [ADDR_W:0]   ptr_reg, ptr_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              ready_reg, ready_next;
  logic [7:0]        drop_reg, drop_next;

  logic              fifo_clear, fifo_push, fifo_pop, fifo_coal;
  logic              fifo_match, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [LW-1:0]     level;

  // The pop is decided apart from the update logic because the FIFO's match
  // result depends on it. Keeping it in its own assignment keeps the
  // pop -> match -> push path acyclic.
  assign fifo_pop = (state_reg == ST_RUN) && !flush_req && !fetch_rd && !fifo_empty;

  btb_write_ctrl_upd_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .coal     (fifo_coal),
    .in_addr  (upd_addr),
    .in_data  (upd_data),
    .match    (fifo_match),
    .head_addr(head_addr),
    .head_data(head_data),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    ready_next = ready_reg;
    drop_next  = drop_reg;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_coal  = 1'b0;

    if (flush_req) begin
      // A flush discards any update arriving in the same cycle.
      fifo_clear = 1'b1;
      state_next = ST_SWEEP;
      ptr_next   = '0;
      ready_next = 1'b0;
    end else begin
      case (state_reg)
        ST_SWEEP: begin
          if (ptr_reg[ADDR_W]) begin
            state_next = ST_RUN;
            ready_next = 1'b1;
          end else if (!fetch_rd) begin
            wen_next   = 1'b1;
            waddr_next = ptr_reg[ADDR_W-1:0];
            wdata_next = '0;
            ptr_next   = ptr_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (fifo_pop) begin
            wen_next   = 1'b1;
            waddr_next = head_addr;
            wdata_next = head_data;
          end
          if (upd_wen) begin
            if (!fetch_rd && fifo_empty) begin
              // The port is idle and nothing is queued, so the update
              // skips the FIFO.
              wen_next   = 1'b1;
              waddr_next = upd_addr;
              wdata_next = upd_data;
            end else if (fifo_match) begin
              fifo_coal = 1'b1;
            end else if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
            end else if (drop_reg != 8'hFF) begin
              drop_next = drop_reg + 8'd1;
            end
          end
        end
        default: begin
          state_next = ST_SWEEP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_SWEEP;
      ptr_reg   <= '0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      ready_reg <= 1'b0;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      ready_reg <= ready_next;
      drop_reg  <= drop_next;
    end
  end

  assign btb_wen    = wen_reg;
  assign btb_waddr  = waddr_reg;
  assign btb_wdata  = wdata_reg;
  assign btb_ready  = ready_reg;
  assign fifo_level = level;
  assign drop_cnt   = drop_reg;

endmodule
